// File: rtl/instr_encode_loader_pkg.sv
// Shared definitions for the instruction encode loader: packed-word field
// positions, gen encodings and the loader FSM state type.
package instr_encode_loader_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 28;
    localparam int unsigned RD_MSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_MSB    = 21;
    localparam int unsigned RS_LSB    = 16;
    // rt shares the imm6 slot in register-register forms
    localparam int unsigned RT_MSB    = 15;
    localparam int unsigned RT_LSB    = 10;
    localparam int unsigned IMM12_MSB = 21;
    localparam int unsigned IMM12_LSB = 10;
    localparam int unsigned IMM6_MSB  = 15;
    localparam int unsigned IMM6_LSB  = 10;

    localparam logic GEN_SVPC = 1'b1;
    localparam logic GEN_ADDI = 1'b0;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StFull
    } state_e;

endpackage

// File: rtl/instr_encode_loader_imm_range_pack.sv
// Range check and truncation of a 32-bit signed immediate into the 12-bit (SVPC)
// or 6-bit (add-immediate) field. IMM_SATURATE_EN clamps misfits instead.
module imm_range_pack
    import instr_encode_loader_pkg::*;
(
    input  logic        gen,
    input  logic [31:0] imm,
    output logic [11:0] imm_bits,
    output logic        fits
);

    logic fits12;
    logic fits6;

    // A value fits when every bit above the field's sign bit copies that sign bit
    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits6  = (imm[31:5]  == {27{imm[5]}});

    always_comb begin
        fits     = (gen == GEN_SVPC) ? fits12 : fits6;
        imm_bits = (gen == GEN_SVPC) ? imm[11:0] : {6'b0, imm[5:0]};
`ifdef IMM_SATURATE_EN
        if (!fits) begin
            if (gen == GEN_SVPC) begin
                imm_bits = imm[31] ? 12'h800 : 12'h7ff;
            end else begin
                imm_bits = imm[31] ? 12'h020 : 12'h01f;
            end
        end
`endif
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Packs decoded instruction fields and writes them sequentially into instruction
// memory, one word per two cycles. Optional macro IMM_SATURATE_EN clamps misfits.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        opcode,
    input  logic [5:0]        rd,
    input  logic [5:0]        rs,
    input  logic              gen,
    input  logic [31:0]       imm,
    input  logic              finish,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
    output logic              err_range
);

`ifdef IMM_SATURATE_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [INSTR_W-1:0]  hold_q, hold_d;
    logic                wr_ok_q, wr_ok_d;
    logic                full_q, full_d;
    logic                err_q, err_d;

    logic [11:0]         imm_bits;
    logic                imm_fits;
    logic [INSTR_W-1:0]  packed_word;
    logic                handshake;
    logic                reached_full;
    logic [ADDR_W:0]     count_inc;

    imm_range_pack u_imm_range_pack (
        .gen      (gen),
        .imm      (imm),
        .imm_bits (imm_bits),
        .fits     (imm_fits)
    );

    always_comb begin
        packed_word = '0;
        packed_word[OPC_MSB:OPC_LSB] = opcode;
        packed_word[RD_MSB:RD_LSB]   = rd;
        if (gen == GEN_SVPC) begin
            packed_word[IMM12_MSB:IMM12_LSB] = imm_bits;
        end else begin
            packed_word[RS_MSB:RS_LSB]     = rs;
            packed_word[IMM6_MSB:IMM6_LSB] = imm_bits[5:0];
        end
    end

    // finish masks in_ready combinationally so it always beats a handshake
    assign in_ready  = (state_q == StAccept) && !finish;
    assign handshake = in_ready && in_valid;
    assign mem_we    = (state_q == StWrite) && wr_ok_q;
    assign count_inc = count_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        hold_d       = hold_q;
        wr_ok_d      = wr_ok_q;
        full_d       = full_q;
        err_d        = err_q;
        reached_full = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccept;
                    addr_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                end
            end
            StAccept: begin
                if (finish) begin
                    state_d = StIdle;
                end else if (handshake) begin
                    hold_d  = packed_word;
                    wr_ok_d = imm_fits || SAT_EN;
                    err_d   = err_q || !imm_fits;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (wr_ok_q) begin
                    count_d = count_inc;
                    // The address saturates at the top instead of wrapping to 0
                    if (addr_q != ADDR_MAX) begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    reached_full = (count_inc == DEPTH_CNT) || (addr_q == ADDR_MAX);
                end
                full_d = full_q || reached_full;
                if (finish) begin
                    state_d = StIdle;
                end else if (reached_full) begin
                    state_d = StFull;
                end else begin
                    state_d = StAccept;
                end
            end
            StFull: begin
                if (finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
            wr_ok_q <= 1'b0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            wr_ok_q <= wr_ok_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = hold_q;
    assign word_count = count_q;
    assign busy       = (state_q != StIdle);
    assign full       = full_q;
    assign err_range  = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed, table-driven bench for instr_encode_loader (ADDR_W=8, DEPTH=4).
// Honours IMM_SATURATE_EN when the RTL is built with it.
module tb_instr_encode_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

`ifdef IMM_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        opcode = '0;
    logic [5:0]        rd = '0;
    logic [5:0]        rs = '0;
    logic              gen = 1'b0;
    logic [31:0]       imm = '0;
    logic              finish = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              full;
    logic              err_range;

    instr_encode_loader #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .rd         (rd),
        .rs         (rs),
        .gen        (gen),
        .imm        (imm),
        .finish     (finish),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .busy       (busy),
        .full       (full),
        .err_range  (err_range)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        g;
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [5:0]  rs;
        logic [31:0] imm;
        logic        we;
        logic [31:0] wdata;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic g, input logic [3:0] op, input logic [5:0] d,
                              input logic [5:0] s, input logic [31:0] im);
        gen    = g;
        opcode = op;
        rd     = d;
        rs     = s;
        imm    = im;
    endtask

    task automatic begin_session(input logic [ADDR_W-1:0] base);
        finish = 1'b1;
        step();
        finish    = 1'b0;
        start     = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    initial begin
        int nwr;
        logic [ADDR_W-1:0] exp_addr;

        vecs[0] = '{1'b0, 4'd4,  6'd3,  6'd5,  32'hFFFF_FFFE, 1'b1, 32'h40C5_F800, 1'b0};
        vecs[1] = '{1'b1, 4'd15, 6'd1,  6'd0,  32'd2047,      1'b1, 32'hF05F_FC00, 1'b0};
        vecs[2] = '{1'b1, 4'd15, 6'd1,  6'd0,  32'd2048,      SAT,  32'hF05F_FC00, 1'b1};
        vecs[3] = '{1'b1, 4'd2,  6'h3F, 6'd0,  32'hFFFF_F800, 1'b1, 32'h2FE0_0000, 1'b0};
        vecs[4] = '{1'b0, 4'd1,  6'd0,  6'h3F, 32'd31,        1'b1, 32'h103F_7C00, 1'b0};
        vecs[5] = '{1'b0, 4'd1,  6'd0,  6'd0,  32'd32,        SAT,  32'h1000_7C00, 1'b1};
        vecs[6] = '{1'b0, 4'd1,  6'd0,  6'd0,  32'hFFFF_FFDF, SAT,  32'h1000_8000, 1'b1};
        vecs[7] = '{1'b0, 4'd0,  6'd0,  6'd0,  32'hFFFF_FFE0, 1'b1, 32'h0000_8000, 1'b0};
        vecs[8] = '{1'b1, 4'd3,  6'd2,  6'h2A, 32'd5,         1'b1, 32'h3080_1400, 1'b0};

        // Reset state
        #3;
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_word_count", 32'(word_count), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_full_err", {30'b0, full, err_range}, 0);
        #10;
        rst_n = 1'b1;
        step();

        // Table-driven packing and range checks, one word per session at 0x10
        for (int i = 0; i < 9; i++) begin
            begin_session(8'h10);
            check($sformatf("v%0d_busy", i), 32'(busy), 1);
            set_bundle(vecs[i].g, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm);
            in_valid = 1'b1;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].we));
            check($sformatf("v%0d_err", i), 32'(err_range), 32'(vecs[i].err));
            check($sformatf("v%0d_in_ready_wr", i), 32'(in_ready), 0);
            if (vecs[i].we) begin
                check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wdata);
                check($sformatf("v%0d_addr", i), 32'(mem_addr), 32'h10);
            end
            step();
            check($sformatf("v%0d_count", i), 32'(word_count), 32'(vecs[i].we));
            check($sformatf("v%0d_addr_after", i), 32'(mem_addr), vecs[i].we ? 32'h11 : 32'h10);
        end

        // Back-to-back stream of 5 bundles with DEPTH=4
        begin_session(8'h00);
        set_bundle(1'b0, 4'd4, 6'd1, 6'd2, 32'd3);
        in_valid = 1'b1;
        nwr = 0;
        exp_addr = '0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (mem_we) begin
                check("stream_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                nwr++;
            end
        end
        check("stream_writes", 32'(nwr), 4);
        check("stream_full", 32'(full), 1);
        check("stream_in_ready", 32'(in_ready), 0);
        check("stream_count", 32'(word_count), 4);
        in_valid = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("full_finish_busy", 32'(busy), 0);
        check("full_held_idle", 32'(full), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("full_cleared_start", 32'(full), 0);

        // finish and in_valid in the same ACCEPT cycle
        begin_session(8'h20);
        set_bundle(1'b0, 4'd1, 6'd1, 6'd1, 32'd1);
        in_valid = 1'b1;
        finish   = 1'b1;
        #1;
        check("fin_mask_in_ready", 32'(in_ready), 0);
        step();
        in_valid = 1'b0;
        finish   = 1'b0;
        check("fin_busy", 32'(busy), 0);
        check("fin_no_write", 32'(mem_we), 0);
        check("fin_count", 32'(word_count), 0);

        // start ignored while busy: writes stay at the original base
        begin_session(8'h40);
        start     = 1'b1;
        base_addr = 8'h80;
        step();
        start = 1'b0;
        set_bundle(1'b0, 4'd2, 6'd2, 6'd2, 32'd2);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("busy_start_we", 32'(mem_we), 1);
        check("busy_start_addr", 32'(mem_addr), 32'h40);
        step();

        // Asynchronous reset during WRITE of the second word
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("rstw_we_before", 32'(mem_we), 1);
        check("rstw_count_before", 32'(word_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_we", 32'(mem_we), 0);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_count", 32'(word_count), 0);
        #4;
        rst_n = 1'b1;
        in_valid = 1'b1;
        nwr = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (mem_we || busy || in_ready) nwr++;
        end
        in_valid = 1'b0;
        check("rstw_idle_ignores", 32'(nwr), 0);

        // Address top: 0xFE, 0xFF then full without wrapping
        begin_session(8'hFE);
        set_bundle(1'b1, 4'd7, 6'd7, 6'd0, 32'd100);
        in_valid = 1'b1;
        nwr = 0;
        exp_addr = 8'hFE;
        for (int c = 0; c < 10; c++) begin
            step();
            if (mem_we) begin
                check("wrap_addr", 32'(mem_addr), 32'(exp_addr));
                exp_addr++;
                nwr++;
            end
        end
        in_valid = 1'b0;
        check("wrap_writes", 32'(nwr), 2);
        check("wrap_full", 32'(full), 1);
        check("wrap_count", 32'(word_count), 2);
        check("wrap_in_ready", 32'(in_ready), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Writer-side counterpart to the immediate generator. It accepts decoded instruction fields plus a full-width signed immediate over a valid/ready handshake.
- It range-checks the immediate, truncates it, and packs it into the 32-bit instruction format.
- It writes the packed words sequentially into instruction memory. Used by the boot/test loader ahead of fetch.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load session at base_addr.
- base_addr  input  ADDR_W  first write address, sampled on start.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  bundle accepted when in_valid && in_ready.
- opcode  input  4  packed to bits [31:28].
- rd  input  6  packed to bits [27:22].
- rs  input  6  packed to bits [21:16], only when gen=0.
- gen  input  1  1 = SVPC form (12-bit imm), 0 = add-immediate form (6-bit imm).
- imm  input  32  signed immediate value.
- finish  input  1  one-cycle pulse; ends the session.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  32  packed instruction.
- word_count  output  ADDR_W+1  words written this session.
- busy  output  1  session active.
- full  output  1  DEPTH words written or address wrapped.
- err_range  output  1  sticky; an immediate did not fit its field.

Behaviour:
- Reset values: every output is 0, the FSM is in IDLE, and the address register is 0. Reset mid-session aborts immediately; partially queued writes are discarded.
- FSM states: IDLE, ACCEPT, WRITE, FULL.
- IDLE → ACCEPT on start. This latches base_addr, clears word_count, err_range and full, and sets busy=1.
- In ACCEPT, in_ready=1. On handshake, the bundle is packed into a holding register and the FSM goes to WRITE.
- WRITE lasts one cycle:
  - mem_we=1 with mem_addr and mem_wdata, and in_ready=0.
  - Then the address increments and word_count increments.
  - Next state is ACCEPT, or FULL if word_count reaches DEPTH or the address would wrap past 2**ADDR_W-1.
- Throughput: one word per 2 cycles. Latency from handshake to mem_we is exactly 1 cycle.
- Packing, gen=1: imm[11:0] goes to bits [21:10]. The fit condition is imm[31:11] all equal to imm[11].
- Packing, gen=0: rs goes to [21:16] and imm[5:0] goes to [15:10]. The fit condition is imm[31:5] all equal to imm[5].
- Bits [9:0] are always 0.
- A misfit immediate sets err_range and the word is dropped: no write, and the counter and address do not advance. The FSM returns to ACCEPT after the same WRITE slot, with mem_we held low.
- finish in ACCEPT returns the FSM to IDLE and sets busy=0. finish in WRITE is honoured after the write completes.
- If finish and a handshake occur in the same cycle, finish wins and the bundle is not accepted (in_ready drops the same cycle via a combinational mask).
- In FULL, in_ready=0 and full=1. Only finish (→ IDLE) or reset leaves FULL. full stays asserted in IDLE until the next start.
- start is ignored while busy.
- in_valid while not busy is ignored, with in_ready=0.

Optional Feature:
- Macro IMM_SATURATE_EN.
- Defined: a misfit immediate is clamped to the field's min/max signed value and written. err_range is still set.
- Undefined: the word is dropped as described in Behaviour.

Decomposition:
- Shared package holds:
  - field position constants (OPC_MSB/LSB, RD, RS, RT, IMM12, IMM6);
  - gen encoding constants GEN_SVPC=1, GEN_ADDI=0;
  - the FSM state enum.
- One natural sub-module: imm_range_pack. It is combinational: inputs gen and imm; outputs the field bits and a fits flag, plus the saturation path when IMM_SATURATE_EN is defined.

Test Plan:
- start with base_addr=0x10; send gen=0, opcode=4, rd=3, rs=5, imm=-2 → one cycle later mem_we=1, mem_addr=0x10, mem_wdata=0x40C5F800, word_count=1.
- gen=1, opcode=15, rd=1, imm=2047 → mem_wdata=0xF05FFC00. Then imm=2048 → no write, err_range=1, word_count unchanged; with IMM_SATURATE_EN, 0x7FF is written instead.
- DEPTH=4, start at 0; stream 5 valid bundles back-to-back → exactly 4 writes at addresses 0..3, full=1 after the 4th, in_ready=0 for the 5th.
- Assert finish in the same cycle as in_valid in ACCEPT → no handshake, no write, busy=0 next cycle.
- Pull rst_n low during WRITE → mem_we, busy and word_count go to 0 immediately (asynchronously); after release the block sits in IDLE ignoring in_valid.
- base_addr=0xFE with ADDR_W=8 → writes at 0xFE and 0xFF, then full=1 with no wrap to 0x00.
